pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the five-stage LEGv8 pipeline (IF/ID/EX/MEM/WB). It generalises the fixed EX/MEM/WB forwarding to a configurable number of post-ID stages and a configurable load latency.
- Internally tracks in-flight destination registers, then generates forwarding selects for the ID-stage operands, load-use stalls, and branch flushes.
- Sits beside the ID stage; its outputs drive the EX operand muxes and the IF/ID and ID/EX pipeline-register enables and clears.

Parameters:
- NUM_REGS, 32, architectural register count.
- REG_W, 5, register index width; must equal $clog2(NUM_REGS).
- FWD_STAGES, 3, tracked stages after ID (EX=stage 0 … WB=stage FWD_STAGES-1); legal range 1..6.
- LOAD_LAT, 1, stages a load result stays unavailable; legal range 0..FWD_STAGES-1.
- ZERO_REG, 31, hard-zero register (XZR); never tracked or forwarded.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_rn  in  REG_W  ID first source register.
- id_rm  in  REG_W  ID second source register (post Reg2Loc mux).
- id_rn_used, id_rm_used  in  1 each  source actually read.
- id_rd  in  REG_W  ID destination register.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is LDUR.
- br_taken  in  1  branch resolved taken in EX this cycle.
- freeze  in  1  global pipeline hold (e.g. memory wait).
- fwd_a, fwd_b  out  $clog2(FWD_STAGES+1) each  0 = register file; k = result of stage k-1.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- flush_if_id, flush_id_ex  out  1 each  clear those pipeline registers.

Behaviour:
- State: FWD_STAGES entries {valid, rd, is_load}. Entry 0 is EX.
- Async reset clears all entries; all outputs then read 0.
- Update per clk edge, in priority order:
  - freeze=1: all entries hold.
  - Otherwise entry[k] <= entry[k-1] for k≥1.
  - entry[0] <= {id_reg_write && id_rd!=ZERO_REG, id_rd, id_is_load}, unless stall or br_taken, in which case entry[0] <= invalid (bubble).
- Match for a source: entry valid && rd == source && source != ZERO_REG && source used.
- fwd_x = k+1 for the lowest (youngest) matching k. No match gives 0.
- Combinational outputs, zero latency; valid the same cycle as the ID inputs.
- Load-use: stall=1 if any youngest-matching entry k has is_load=1 and k < LOAD_LAT. fwd_x is don't-care while stall=1, but must hold a legal value.
- With LOAD_LAT=0, stall from load-use never asserts.
- br_taken=1: flush_if_id=1, flush_id_ex=1, stall forced 0; branch wins over load-use.
- freeze=1: stall=1, flushes 0, no bubble inserted (state holds). Freeze wins over br_taken; the branch is re-presented after freeze drops.
- Same-register write in two stages: the youngest entry wins.
- Reset asserted mid-stall or mid-flush: outputs drop to 0 asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each clock with load-use stall=1 and freeze=0.
  - flush_cnt increments on each clock with br_taken=1 and freeze=0.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - struct hz_entry_t {valid, rd, is_load}.
  - Localparam FWD_W = $clog2(FWD_STAGES+1), exposed through a function.
  - Constant FWD_REGFILE = 0.
- Sub-module hazard_tracker: the parametrised entry shift register, with freeze/bubble control and async reset.
- The top level holds the match/priority logic, stall/flush decode, and the optional counters.

Test Plan:
- ALU-ALU dependency: ADD X1,X2,X3 then SUB X4,X1,X5 (defaults) -> SUB in ID sees fwd_a=1, stall=0. One NOP between them -> fwd_a=2.
- Load-use: LDUR X2,[X0,#0] then ADD X3,X2,X2 -> stall=1 for exactly 1 cycle, EX bubble, then fwd_a=fwd_b=2. Repeat with LOAD_LAT=2 -> stall for 2 cycles.
- XZR: ADD X31,… then ADD X5,X31,X31 -> fwd_a=fwd_b=0, stall=0. Same result for a load to X31.
- Branch precedence: br_taken=1 in the same cycle as a load-use match -> flush_if_id=flush_id_ex=1, stall=0. Next cycle entry[0] is invalid.
- Freeze: freeze=1 for 3 cycles with a dependency pending -> entries unchanged and stall=1 throughout. After release, forwarding resumes with identical fwd values.
- Reset: assert reset mid load-use stall -> stall, fwd_*, and flushes go to 0 immediately. After release, no stale forwarding occurs. With HAZARD_PERF_CNT_EN, the counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard/forwarding unit.
// Optional macro HAZARD_PERF_CNT_EN is consumed by pipe_hazard_unit only.
package hazard_pkg;

  // rd is stored at a fixed, generous width so the struct is shared across REG_W choices
  localparam int unsigned HZ_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               is_load;
  } hz_entry_t;

  function automatic int unsigned fwd_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

  localparam int unsigned FWD_STAGES_DEFAULT = 3;
  localparam int unsigned FWD_W              = fwd_width(FWD_STAGES_DEFAULT);
  localparam int unsigned FWD_REGFILE        = 0;

endpackage

// File: rtl/hazard_tracker.sv
// In-flight destination tracker: one entry per post-ID stage, entry 0 = EX.
// Freeze holds every entry; bubble loads an invalid entry into EX.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   freeze,
  input  logic                   bubble,
  input  hz_entry_t              new_entry,
  output hz_entry_t [STAGES-1:0] entries
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '0;
    end else if (!freeze) begin
      entries[0] <= bubble ? hz_entry_t'('0) : new_entry;
      for (int unsigned k = 1; k < STAGES; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding select, load-use stall and branch flush generation for ID.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush event counters.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [REG_W-1:0]                    id_rn,
  input  logic [REG_W-1:0]                    id_rm,
  input  logic                                id_rn_used,
  input  logic                                id_rm_used,
  input  logic [REG_W-1:0]                    id_rd,
  input  logic                                id_reg_write,
  input  logic                                id_is_load,
  input  logic                                br_taken,
  input  logic                                freeze,
  output logic [fwd_width(FWD_STAGES)-1:0]    fwd_a,
  output logic [fwd_width(FWD_STAGES)-1:0]    fwd_b,
  output logic                                stall,
  output logic                                flush_if_id,
  output logic                                flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                         stall_cnt,
  output logic [31:0]                         flush_cnt
`endif
);

  localparam int unsigned SEL_W = fwd_width(FWD_STAGES);
  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  if (REG_W != $clog2(NUM_REGS) || REG_W > HZ_RD_W || FWD_STAGES < 1 ||
      FWD_STAGES > 6 || LOAD_LAT >= FWD_STAGES || ZERO_REG >= NUM_REGS) begin : g_bad_params
    $error("pipe_hazard_unit: illegal parameter combination");
  end

  hz_entry_t [FWD_STAGES-1:0] entries;
  hz_entry_t                  new_entry;
  logic                       load_use;
  logic                       bubble;
  logic [SEL_W-1:0]           sel_a, sel_b;
  logic                       hit_a, hit_b;
  logic                       lu_a, lu_b;

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = id_reg_write && (id_rd != XZR);
    new_entry.rd      = HZ_RD_W'(id_rd);
    new_entry.is_load = id_is_load;
  end

  // Only the youngest match per source decides both the select and the load-use check
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!hit_a && id_rn_used && id_rn != XZR && entries[k].valid &&
          entries[k].rd == HZ_RD_W'(id_rn)) begin
        hit_a = 1'b1;
        sel_a = SEL_W'(k + 1);
        lu_a  = entries[k].is_load && (k < LOAD_LAT);
      end
      if (!hit_b && id_rm_used && id_rm != XZR && entries[k].valid &&
          entries[k].rd == HZ_RD_W'(id_rm)) begin
        hit_b = 1'b1;
        sel_b = SEL_W'(k + 1);
        lu_b  = entries[k].is_load && (k < LOAD_LAT);
      end
    end
  end

  assign load_use = lu_a || lu_b;
  assign bubble   = load_use || br_taken;

  hazard_tracker #(
    .STAGES (FWD_STAGES)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .freeze    (freeze),
    .bubble    (bubble),
    .new_entry (new_entry),
    .entries   (entries)
  );

  // Priority: reset, then freeze, then branch, then load-use
  always_comb begin
    fwd_a       = '0;
    fwd_b       = '0;
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      fwd_a = sel_a;
      fwd_b = sel_b;
      if (freeze) begin
        stall = 1'b1;
      end else if (br_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else begin
        stall = load_use;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      if (load_use && !br_taken && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (br_taken && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default build plus a LOAD_LAT=2 instance.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic       id_rn_used = 1'b0, id_rm_used = 1'b0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0;
  logic       br_taken = 1'b0, freeze = 1'b0;

  logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic       stall, flush_if_id, flush_id_ex;
  logic       stall2, flush_if_id2, flush_id_ex2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rn_used   (id_rn_used),
    .id_rm_used   (id_rm_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .br_taken     (br_taken),
    .freeze       (freeze),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall        (stall),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  pipe_hazard_unit #(
    .LOAD_LAT (2)
  ) dut_lat2 (
    .clk          (clk),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rn_used   (id_rn_used),
    .id_rm_used   (id_rm_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .br_taken     (br_taken),
    .freeze       (freeze),
    .fwd_a        (fwd_a2),
    .fwd_b        (fwd_b2),
    .stall        (stall2),
    .flush_if_id  (flush_if_id2),
    .flush_id_ex  (flush_id_ex2)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt2),
    .flush_cnt    (flush_cnt2)
`endif
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm, input logic rn_u,
                        input logic rm_u, input logic [4:0] rd, input logic wr, input logic ld);
    id_rn = rn; id_rm = rm; id_rn_used = rn_u; id_rm_used = rm_u;
    id_rd = rd; id_reg_write = wr; id_is_load = ld;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    nop();
    br_taken = 1'b0;
    freeze   = 1'b0;
    reset    = 1'b1;
    #2;
    reset    = 1'b0;
    tick();
  endtask

  initial begin
    #3;
    check("reset_fwd_a", fwd_a, 0);
    check("reset_fwd_b", fwd_b, 0);
    check("reset_stall", stall, 0);
    check("reset_flush", {flush_if_id, flush_id_ex}, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_cnt", stall_cnt | flush_cnt, 0);
`endif
    reset = 1'b0;
    tick();

    // ADD X1,X2,X3 ; SUB X4,X1,X5
    set_id(5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0); #1;
    check("add_empty_fwd", fwd_a, 0);
    tick();
    set_id(5'd1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    check("alu_alu_fwd_a", fwd_a, 1);
    check("alu_alu_fwd_b", fwd_b, 0);
    check("alu_alu_stall", stall, 0);

    // ADD X1 ; NOP ; SUB X4,X1 ; then X1 sits in WB
    do_reset();
    set_id(5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0); tick();
    nop(); tick();
    set_id(5'd1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    check("nop_gap_fwd_a", fwd_a, 2);
    tick();
    set_id(5'd1, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    check("wb_stage_fwd_a", fwd_a, 3);
    check("ex_stage_fwd_b", fwd_b, 1);
    tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0); #1;
    check("retired_fwd_a", fwd_a, 0);

    // Two writers of X7: youngest wins
    do_reset();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); tick();
    set_id(5'd7, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0); #1;
    check("youngest_fwd_a", fwd_a, 1);
    check("unused_rm_fwd_b", fwd_b, 0);

    // Load-use: LDUR X2 ; ADD X3,X2,X2
    do_reset();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    check("ldu_stall_c1", stall, 1);
    check("ldu2_stall_c1", stall2, 1);
    tick();
    check("ldu_stall_c2", stall, 0);
    check("ldu_fwd_a", fwd_a, 2);
    check("ldu_fwd_b", fwd_b, 2);
    check("ldu2_stall_c2", stall2, 1);
    tick();
    check("ldu2_stall_c3", stall2, 0);
    check("ldu2_fwd_a", fwd_a2, 3);
    check("ldu2_fwd_b", fwd_b2, 3);

    // XZR writes never forward, ALU or load
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0); tick();
    set_id(5'd31, 5'd31, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    check("xzr_alu_fwd", {fwd_a, fwd_b}, 0);
    check("xzr_alu_stall", stall, 0);
    do_reset();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1); tick();
    set_id(5'd31, 5'd31, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    check("xzr_ld_fwd", {fwd_a, fwd_b}, 0);
    check("xzr_ld_stall", stall, 0);

    // Branch beats load-use; ADD is not inserted into EX
    do_reset();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    br_taken = 1'b1; #1;
    check("br_flush_if_id", flush_if_id, 1);
    check("br_flush_id_ex", flush_id_ex, 1);
    check("br_stall", stall, 0);
    tick();
    br_taken = 1'b0;
    set_id(5'd3, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #1;
    check("br_bubble_fwd_a", fwd_a, 0);
    check("br_load_fwd_b", fwd_b, 2);
    check("br_after_stall", stall, 0);

    // Freeze holds state for 3 cycles and overrides a branch
    do_reset();
    set_id(5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0); tick();
    set_id(5'd1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    freeze = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      br_taken = (i == 1);
      #1;
      check("frz_stall", stall, 1);
      check("frz_fwd_a", fwd_a, 1);
      check("frz_no_flush", {flush_if_id, flush_id_ex}, 0);
      tick();
    end
    freeze = 1'b0;
    br_taken = 1'b0; #1;
    check("frz_rel_fwd_a", fwd_a, 1);
    check("frz_rel_stall", stall, 0);

    // Async reset during load-use stall with a branch pending
    do_reset();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    check("rst_pre_stall", stall, 1);
    #1;
    reset = 1'b1;
    br_taken = 1'b1; #1;
    check("rst_mid_stall", stall, 0);
    check("rst_mid_fwd", {fwd_a, fwd_b}, 0);
    check("rst_mid_flush", {flush_if_id, flush_id_ex}, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_mid_cnt", stall_cnt | flush_cnt, 0);
`endif
    br_taken = 1'b0;
    #1;
    reset = 1'b0; #1;
    check("rst_no_stale_fwd", {fwd_a, fwd_b}, 0);
    check("rst_no_stale_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
